// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register file.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for pending writebacks: issue sets, writeback clears, set wins.
// REG_FILE_BYPASS_EN: a port reading the register being written sees the post-update busy bit.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W-1:0] rd_a [NUM_RD];
    logic [NUM_RD-1:0] rd_busy_d;

    // Clear first, then set, so a re-issue in the writeback cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[ADDR_W'(ZERO_REG)] = 1'b0;
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_a[p] = rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rd_busy_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy_d[p] = busy_q[rd_a[p]];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en && (rd_a[p] == wr_addr)) begin
                rd_busy_d[p] = busy_d[rd_a[p]];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rd_busy  <= '0;
            any_busy <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rd_busy  <= rd_busy_d;
            any_busy <= |busy_d;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads, hardwired r0 and busy scoreboard.
// REG_FILE_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module reg_file_mp
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_busy
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] rd_a [NUM_RD];
    logic [DATA_W-1:0] rd_d [NUM_RD];
    logic              wr_act;

    assign wr_act = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_act) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_a[p] = rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_d[p] = regs[rd_a[p]];
`ifdef REG_FILE_BYPASS_EN
            if (wr_act && (rd_a[p] == wr_addr)) begin
                rd_d[p] = wr_data;
            end
`endif
            if (rd_a[p] == ADDR_W'(ZERO_REG)) begin
                rd_d[p] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data[p*DATA_W +: DATA_W] <= rd_d[p];
            end
        end
    end

    reg_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default 32x32/2-port instance and a 64x16/4-port instance.
module tb_reg_file_mp;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // Default configuration DUT
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    reg_addr_t   iss_addr;
    logic        any_busy;

    // Wide configuration DUT
    logic [15:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_wr_en;
    logic [3:0]   w_wr_addr;
    logic [63:0]  w_wr_data;
    logic         w_iss_en;
    logic [3:0]   w_iss_addr;
    logic         w_any_busy;

    reg_file_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    reg_file_mp #(
        .DATA_W (64),
        .DEPTH  (16),
        .NUM_RD (4)
    ) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (w_rd_addr),
        .rd_data  (w_rd_data),
        .rd_busy  (w_rd_busy),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .iss_en   (w_iss_en),
        .iss_addr (w_iss_addr),
        .any_busy (w_any_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        any;
    } exp_t;

    typedef struct {
        string        tag;
        logic [255:0] d;
    } wexp_t;

    exp_t  sb_q [$];
    wexp_t wsb_q [$];

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [63:0] w_regs [16];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 16; i++) w_regs[i] = '0;
        m_busy = '0;
    endtask

    // One clock of stimulus on the default DUT; expectation queued, then checked after the edge.
    task automatic step(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia);
        exp_t        e;
        exp_t        g;
        logic [31:0] nb;
        logic [4:0]  aa [2];
        logic [31:0] dd [2];
        logic [1:0]  bb;
        rd_addr  = {a1, a0};
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        nb = m_busy;
        if (we) nb[wa] = 1'b0;
        if (ie) nb[ia] = 1'b1;
        nb[0] = 1'b0;
        aa[0] = a0;
        aa[1] = a1;
        for (int p = 0; p < 2; p++) begin
            dd[p] = m_regs[aa[p]];
            bb[p] = m_busy[aa[p]];
`ifdef REG_FILE_BYPASS_EN
            if (we && aa[p] == wa) begin
                dd[p] = wd;
                bb[p] = nb[aa[p]];
            end
`endif
            if (aa[p] == 5'd0) begin
                dd[p] = '0;
                bb[p] = 1'b0;
            end
        end
        e.tag  = tag;
        e.d0   = dd[0];
        e.d1   = dd[1];
        e.busy = bb;
        e.any  = |nb;
        sb_q.push_back(e);
        if (we && wa != 5'd0) m_regs[wa] = wd;
        m_busy = nb;
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk({g.tag, "_d0"}, 64'(rd_data[31:0]), 64'(g.d0));
        chk({g.tag, "_d1"}, 64'(rd_data[63:32]), 64'(g.d1));
        chk({g.tag, "_busy"}, 64'(rd_busy), 64'(g.busy));
        chk({g.tag, "_any"}, 64'(any_busy), 64'(g.any));
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        logic [3:0] wa [4];
        wexp_t      we_e;
        wexp_t      we_g;

        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        iss_en     = 1'b0;
        iss_addr   = '0;
        w_rd_addr  = '0;
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        w_iss_en   = 1'b0;
        w_iss_addr = '0;
        model_reset();

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        chk("por_data", rd_data, 64'd0);
        chk("por_busy", 64'(rd_busy), 64'd0);
        chk("por_any", 64'(any_busy), 64'd0);
        #9 rst_n = 1'b1;

        // Basic write/read and writing zero
        step("wr_r5", 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        step("rd_r5", 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("rd_r5_const", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step("wr0_r5", 5'd0, 5'd0, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0);
        step("rd0_r5", 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Register 0 is hardwired
        step("wr_r0", 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
        step("rd_r0", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Same-cycle write/read
        step("wr_r7", 5'd0, 5'd0, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0);
        step("byp_r7", 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
`ifdef REG_FILE_BYPASS_EN
        chk("byp_r7_const", 64'(rd_data[31:0]), 64'hA5A5A5A5);
`else
        chk("byp_r7_const", 64'(rd_data[31:0]), 64'h1);
`endif
        step("rd_r7", 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("rd_r7_const", 64'(rd_data[31:0]), 64'hA5A5A5A5);

        // Scoreboard
        step("iss_r9", 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        step("busy_r9", 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("busy_r9_const", 64'({rd_busy, any_busy}), 64'b111);
        step("iss_wr_r9", 5'd9, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
        step("still_r9", 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("still_r9_const", 64'({rd_busy[0], any_busy}), 64'b11);
        step("wb_r9", 5'd9, 5'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
        step("free_r9", 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("free_r9_const", 64'({rd_busy[0], any_busy}), 64'b00);

        // Asynchronous reset mid-cycle discards an in-flight write and issue
        step("pre_rst", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        rd_addr  = {5'd7, 5'd5};
        wr_en    = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hCAFEF00D;
        iss_en   = 1'b1;
        iss_addr = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rd_data, 64'd0);
        chk("mid_rst_busy", 64'(rd_busy), 64'd0);
        chk("mid_rst_any", 64'(any_busy), 64'd0);
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        iss_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 1; i < 32; i++) begin
            step($sformatf("zero_r%0d", i), 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        end

        // Wide instance: 64-bit data, 16 registers, 4 read ports
        for (int i = 1; i < 16; i++) begin
            w_wr_en   = 1'b1;
            w_wr_addr = 4'(i);
            w_wr_data = {32'hC0DE0000 + 32'(i), ~(32'(i) * 32'd3)};
            w_regs[i] = w_wr_data;
            @(posedge clk);
            #1;
        end
        w_wr_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) begin
                wa[k] = (c == 4 && k == 2) ? 4'd0 : 4'(((c * 4 + k) % 15) + 1);
            end
            w_rd_addr = {wa[3], wa[2], wa[1], wa[0]};
            we_e.tag = $sformatf("wide_c%0d", c);
            we_e.d   = {w_regs[wa[3]], w_regs[wa[2]], w_regs[wa[1]], w_regs[wa[0]]};
            wsb_q.push_back(we_e);
            @(posedge clk);
            #1;
            we_g = wsb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_p%0d", we_g.tag, k), w_rd_data[k*64 +: 64], we_g.d[k*64 +: 64]);
            end
            chk({we_g.tag, "_busy"}, 64'({w_rd_busy, w_any_busy}), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the MIPS datapath with registered reads, hardwired-zero register 0, asynchronous clear, and a per-register busy scoreboard for pending writebacks. It sits between decode (read addresses, issue of destination register) and writeback (write port). It replaces the fixed 2-read, 32×32 register file in the pipelined core.

## Interface
Parameters:
- DATA_W, 32, width of each register
- DEPTH, 32, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of read ports (1–4)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  registered busy flag of each addressed register
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register
- wr_data  in  DATA_W  write data
- iss_en  in  1  mark a destination register as pending
- iss_addr  in  ADDR_W  destination register being issued
- any_busy  out  1  registered OR of all busy bits

## Operation
- Storage: DEPTH×DATA_W array `regs`, plus `busy[DEPTH]` bit vector.
- Write: on posedge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data. Writing value 0 is a normal write; it is gated only by wr_en.
- Register 0: writes ignored, always reads 0, busy[0] never set.
- Scoreboard: iss_en=1, iss_addr≠0 sets busy[iss_addr]; wr_en=1 clears busy[wr_addr]. Same register set and cleared in the same cycle: set wins (newer producer outstanding). Issue to an already-busy register leaves it busy.
- Read: every posedge, for each port p, rd_data[p] and rd_busy[p] are captured from the addressed register (see Configuration for same-cycle write interaction). Address 0 returns data 0, busy 0.
- any_busy: registered OR of the post-update busy vector.
- Out-of-range addresses (DEPTH not power of two is disallowed) do not exist.

## Timing
- Reset (rst_n=0, asynchronous): all regs=0, all busy=0, rd_data=0, rd_busy=0, any_busy=0. Takes effect immediately, mid-operation included; a write in the reset cycle is discarded.
- Write latency: value is stored at the edge where wr_en is sampled; visible in the array from the next cycle.
- Read latency: 1 cycle; rd_addr sampled at edge N, rd_data valid after edge N until edge N+1.
- Busy set/clear visible in state one cycle after iss_en/wr_en; any_busy reflects it after the same edge.
- Multiple read ports addressing the same register return identical values in the same cycle.

## Configuration
- REG_FILE_BYPASS_EN defined: a read port whose rd_addr equals wr_addr (≠0) with wr_en=1 in the same cycle captures wr_data, and rd_busy captures the post-update busy bit (cleared unless simultaneously re-issued).
- Undefined: read ports capture the pre-write array value and pre-update busy bit; new data is seen one cycle later.

## Structure
- Shared package `mips_pkg`: default DATA_W/DEPTH constants, `ZERO_REG` address constant, `reg_addr_t` typedef.
- One sub-module `reg_scoreboard` (busy vector, set/clear priority, any_busy); the data array and read ports stay in the top.

## Test plan
- Reset: drive writes, assert rst_n low mid-cycle -> all outputs 0 immediately; after release, reading regs 1..31 returns 0.
- Write/read: write 0xDEADBEEF to r5, next cycle read r5 on port 0 and r0 on port 1 -> rd_data0=0xDEADBEEF, rd_data1=0; then write 0x0 to r5 -> r5 reads 0.
- Register 0: wr_en=1, wr_addr=0, wr_data=0x12345678; iss_en to r0 -> read r0 returns 0, busy 0, any_busy 0.
- Same-cycle write/read of r7 with 0xA5A5A5A5 (old 0x1): with REG_FILE_BYPASS_EN rd_data=0xA5A5A5A5; without it rd_data=0x1, next read 0xA5A5A5A5.
- Scoreboard: iss r9 -> rd_busy=1, any_busy=1; iss r9 and write r9 same cycle -> still busy; write r9 alone -> busy 0, any_busy 0.
- Parameters DATA_W=64, DEPTH=16, NUM_RD=4: write distinct values to r1..r15, read four different registers per cycle -> all match.
